// File: rtl/pcpi_mul_iter_if.sv
// PCPI bus bundle between the core (master) and the multiply coprocessor (slave).
interface pcpi_mul_iter_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/pcpi_mul_iter.sv
// Iterative shift-add PCPI responder for MUL/MULH/MULHSU/MULHU; STEPS_AT_ONCE bits per cycle.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module pcpi_mul_iter #(
  parameter int STEPS_AT_ONCE = 1
) (
  input  logic           clk,
  input  logic           reset,
  pcpi_mul_iter_if.slave pcpi
);

  localparam int N = 32 / STEPS_AT_ONCE;
  localparam logic [5:0] CNT_LAST = 6'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_FINISH  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      state_q;
  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic        neg_q;
  logic        hi_q;
  logic [5:0]  cnt_q;
  logic        wait_q;
  logic        ready_q;
  logic [31:0] rd_q;

  logic        insn_match;
  logic [1:0]  funct3_lo;
  logic        rs1_signed;
  logic        rs2_signed;
  logic        rs1_neg;
  logic        rs2_neg;
  logic [31:0] rs1_mag_d;
  logic [31:0] rs2_mag_d;
  logic [63:0] pp_d;
  logic [63:0] acc_d;
  logic [31:0] mplier_d;
  logic [63:0] res_d;
  logic        last_step;

  assign insn_match = (pcpi.pcpi_insn[6:0] == 7'b0110011) &&
                      (pcpi.pcpi_insn[31:25] == 7'b0000001) &&
                      !pcpi.pcpi_insn[14];
  assign funct3_lo  = pcpi.pcpi_insn[13:12];

  // MUL only needs the low half, so it is treated as unsigned x unsigned.
  assign rs1_signed = (funct3_lo == 2'b01) || (funct3_lo == 2'b10);
  assign rs2_signed = (funct3_lo == 2'b01);
  assign rs1_neg    = rs1_signed && pcpi.pcpi_rs1[31];
  assign rs2_neg    = rs2_signed && pcpi.pcpi_rs2[31];
  assign rs1_mag_d  = rs1_neg ? (~pcpi.pcpi_rs1 + 32'd1) : pcpi.pcpi_rs1;
  assign rs2_mag_d  = rs2_neg ? (~pcpi.pcpi_rs2 + 32'd1) : pcpi.pcpi_rs2;

  always_comb begin
    pp_d = '0;
    for (int j = 0; j < STEPS_AT_ONCE; j++) begin
      if (mplier_q[j]) pp_d = pp_d + (mcand_q << j);
    end
    acc_d    = acc_q + pp_d;
    mplier_d = mplier_q >> STEPS_AT_ONCE;
    res_d    = neg_q ? (~acc_q + 64'd1) : acc_q;
  end

`ifdef MUL_EARLY_EXIT_EN
  assign last_step = (cnt_q == CNT_LAST) || (mplier_d == '0);
`else
  assign last_step = (cnt_q == CNT_LAST);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      cnt_q    <= '0;
      wait_q   <= 1'b0;
      ready_q  <= 1'b0;
      rd_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          if (pcpi.pcpi_valid && insn_match) begin
            acc_q    <= '0;
            mcand_q  <= {32'd0, rs1_mag_d};
            mplier_q <= rs2_mag_d;
            neg_q    <= rs1_neg ^ rs2_neg;
            hi_q     <= (funct3_lo != 2'b00);
            cnt_q    <= '0;
            wait_q   <= 1'b1;
`ifdef MUL_EARLY_EXIT_EN
            state_q  <= (rs2_mag_d == '0) ? S_FINISH : S_BUSY;
`else
            state_q  <= S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          if (!pcpi.pcpi_valid) begin
            // Core abandoned the instruction: drop the claim silently.
            wait_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << STEPS_AT_ONCE;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_q + 6'd1;
            if (last_step) state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          rd_q    <= hi_q ? res_d[63:32] : res_d[31:0];
          ready_q <= 1'b1;
          wait_q  <= 1'b0;
          state_q <= S_RELEASE;
        end
        default: begin
          // Hold here until valid drops so a lingering valid cannot re-issue.
          ready_q <= 1'b0;
          if (!pcpi.pcpi_valid) state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pcpi.pcpi_wr    = ready_q;
  assign pcpi.pcpi_ready = ready_q;
  assign pcpi.pcpi_wait  = wait_q;
  assign pcpi.pcpi_rd    = rd_q;

endmodule

// File: tb/tb_pcpi_mul_iter.sv
// Scoreboard bench for pcpi_mul_iter: driver queues expected results, monitor checks on each ready.
module tb_pcpi_mul_iter;
  localparam int S = 1;

  typedef struct {
    logic [31:0] rd;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  pcpi_mul_iter_if bus ();

  pcpi_mul_iter #(.STEPS_AT_ONCE(S)) dut (
    .clk   (clk),
    .reset (reset),
    .pcpi  (bus.slave)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  logic wait_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic int exp_lat(input logic [31:0] mag);
`ifdef MUL_EARLY_EXIT_EN
    int bl;
    bl = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
    return (bl == 0) ? 1 : ((bl + S - 1) / S) + 1;
`else
    return 32 / S + 1 + 0 * int'(mag[0]);
`endif
  endfunction

  // Monitor: pops one expectation per ready pulse.
  always @(negedge clk) begin
    if (reset) begin
      wait_prev = 1'b0;
    end else begin
      if (bus.pcpi_wait && !wait_prev) acc_cyc = cyc;
      if (bus.pcpi_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ready", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd", {32'd0, bus.pcpi_rd}, {32'd0, e.rd});
          chk("wr_eq_ready", {63'd0, bus.pcpi_wr}, 64'd1);
          chk("wait_during_ready", {63'd0, bus.pcpi_wait}, 64'd0);
          chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
        end
      end
      wait_prev = bus.pcpi_wait;
    end
  end

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] rd, input logic [31:0] mag2, input int hold);
    exp_t e;
    bit   got;
    e.rd  = rd;
    e.lat = exp_lat(mag2);
    exp_q.push_back(e);
    bus.pcpi_insn  = mk_insn(f3);
    bus.pcpi_rs1   = a;
    bus.pcpi_rs2   = b;
    bus.pcpi_valid = 1'b1;
    @(negedge clk);
    chk("accept_wait", {63'd0, bus.pcpi_wait}, 64'd1);
    got = bus.pcpi_ready;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = bus.pcpi_ready;
    end
    if (!got) chk("ready_timeout", 64'd0, 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_no_restart", {62'd0, bus.pcpi_wait, bus.pcpi_ready}, 64'd0);
    end
    bus.pcpi_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int seen;
    reset          = 1'b1;
    bus.pcpi_valid = 1'b0;
    bus.pcpi_insn  = '0;
    bus.pcpi_rs1   = '0;
    bus.pcpi_rs2   = '0;
    repeat (3) @(negedge clk);
    chk("rst_wait",  {63'd0, bus.pcpi_wait},  64'd0);
    chk("rst_ready", {63'd0, bus.pcpi_ready}, 64'd0);
    chk("rst_wr",    {63'd0, bus.pcpi_wr},    64'd0);
    chk("rst_rd",    {32'd0, bus.pcpi_rd},    64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(3'b000, 32'd20,        32'd3,        32'd60,        32'd3,        0);
    do_op(3'b001, 32'hFFFFFFEC,  32'd3,        32'hFFFFFFFF,  32'd3,        0);
    do_op(3'b010, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF,  32'd2,        0);
    do_op(3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE,  32'hFFFFFFFF, 0);
    do_op(3'b001, 32'h80000000,  32'h80000000, 32'h40000000,  32'h80000000, 0);
    do_op(3'b000, 32'h80000000,  32'hFFFFFFFF, 32'h80000000,  32'hFFFFFFFF, 2);
    do_op(3'b000, 32'd20,        32'd0,        32'd0,         32'd0,        0);

    // Abort: valid sampled low at the fifth BUSY edge.
    bus.pcpi_insn  = mk_insn(3'b011);
    bus.pcpi_rs1   = 32'd5;
    bus.pcpi_rs2   = 32'hFFFFFFFF;
    bus.pcpi_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.pcpi_valid = 1'b0;
    @(negedge clk);
    chk("abort_wait", {63'd0, bus.pcpi_wait}, 64'd0);
    repeat (40) @(negedge clk);

    // Second operation killed by reset mid-BUSY.
    bus.pcpi_valid = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_wait",  {63'd0, bus.pcpi_wait},  64'd0);
    chk("midrst_ready", {63'd0, bus.pcpi_ready}, 64'd0);
    chk("midrst_wr",    {63'd0, bus.pcpi_wr},    64'd0);
    chk("midrst_rd",    {32'd0, bus.pcpi_rd},    64'd0);
    bus.pcpi_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    do_op(3'b000, 32'd7, 32'd6, 32'd42, 32'd6, 0);

    // Non-multiply instructions must never be claimed.
    seen = 0;
    bus.pcpi_insn  = mk_insn(3'b100);
    bus.pcpi_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.pcpi_wait || bus.pcpi_ready) seen++;
    end
    chk("div_ignored", 64'(seen), 64'd0);
    seen = 0;
    bus.pcpi_insn = 32'h00000013;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.pcpi_wait || bus.pcpi_ready) seen++;
    end
    chk("nonm_ignored", 64'(seen), 64'd0);
    bus.pcpi_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
